// File: rtl/inverter_tester.sv
// Hex-inverter production tester: applies a fixed 14-vector table to a_out, waits for the
// device to settle, compares the synchronized y_in against the ideal inverse and reports per-run results.
module inverter_tester #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] y_in,
  output logic [5:0] a_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask,
  output logic [3:0] err_count,
  output logic [3:0] vec_idx
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_VEC    = 4'd13;
  localparam logic [3:0] ERR_MAX     = 4'd14;

  state_t     state_q, state_d;
  logic [3:0] vec_idx_q, vec_idx_d;
  logic [5:0] a_out_q, a_out_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] fail_mask_q, fail_mask_d;
  logic [3:0] err_count_q, err_count_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [5:0] y_meta_q, y_meta_d;
  logic [5:0] y_sync_q, y_sync_d;
  logic [5:0] diff;

  // all-zero, all-one, walking one, walking zero
  function automatic logic [5:0] vector_at(input logic [3:0] idx);
    logic [5:0] v;
    case (idx)
      4'd0:    v = 6'h00;
      4'd1:    v = 6'h3F;
      4'd2:    v = 6'h01;
      4'd3:    v = 6'h02;
      4'd4:    v = 6'h04;
      4'd5:    v = 6'h08;
      4'd6:    v = 6'h10;
      4'd7:    v = 6'h20;
      4'd8:    v = 6'h3E;
      4'd9:    v = 6'h3D;
      4'd10:   v = 6'h3B;
      4'd11:   v = 6'h37;
      4'd12:   v = 6'h2F;
      4'd13:   v = 6'h1F;
      default: v = 6'h00;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_idx_q   <= 4'd0;
      a_out_q     <= 6'h00;
      cnt_q       <= 8'd0;
      fail_mask_q <= 6'h00;
      err_count_q <= 4'd0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      y_meta_q    <= 6'h00;
      y_sync_q    <= 6'h00;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      a_out_q     <= a_out_d;
      cnt_q       <= cnt_d;
      fail_mask_q <= fail_mask_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      y_meta_q    <= y_meta_d;
      y_sync_q    <= y_sync_d;
    end
  end

  // Status outputs are registered alongside the state so they change on the same edge.
  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    a_out_d     = a_out_q;
    cnt_d       = cnt_q;
    fail_mask_d = fail_mask_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    y_meta_d    = y_in;
    y_sync_d    = y_meta_q;
    diff        = y_sync_q ^ ~a_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SETTLE;
          vec_idx_d   = 4'd0;
          a_out_d     = vector_at(4'd0);
          cnt_d       = 8'd0;
          fail_mask_d = 6'h00;
          err_count_d = 4'd0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        fail_mask_d = fail_mask_q | diff;
        if ((diff != 6'h00) && (err_count_q < ERR_MAX)) begin
          err_count_d = err_count_q + 4'd1;
        end
        if (vec_idx_q == LAST_VEC) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_mask_d == 6'h00);
        end else begin
          state_d   = SETTLE;
          vec_idx_d = vec_idx_q + 4'd1;
          a_out_d   = vector_at(vec_idx_q + 4'd1);
          cnt_d     = 8'd0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a_out     = a_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign err_count = err_count_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_inverter_tester.sv
// Self-checking bench for inverter_tester: fault-injecting channel models, a table-driven
// reference for run results and latency, plus reset-abort and start-handling scenarios.
`timescale 1ns/1ps
module tb_inverter_tester;

  localparam int CLK_HALF = 5;
  localparam int S_MAIN   = 16;
  localparam int S_FAST   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, startF;
  logic [5:0] aOut, aOutF, yIn, yInF;
  logic       busy, busyF, done, doneF, pass, passF;
  logic [5:0] failMask, failMaskF;
  logic [3:0] errCount, errCountF, vecIdx, vecIdxF;

  int         mode;
  logic [5:0] stuck0, stuck1, invMask;
  bit         sel;
  int         compared   = 0;
  int         mismatched = 0;

  logic       obsBusy, obsDone, obsPass;
  logic [5:0] obsA, obsMask;
  logic [3:0] obsErr, obsVec;

  logic [5:0] vecTable [14] = '{6'h00, 6'h3F, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10,
                               6'h20, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  // Clock generator shared by both DUT instances
  always #CLK_HALF clk = ~clk;

  // Behavioural channel model: 0 ideal, 1 ch3 stuck high, 2 ch0/ch1 shorted, 3 stuck/invert masks
  function automatic logic [5:0] channelModel(input logic [5:0] a, input int m,
                                              input logic [5:0] s0, input logic [5:0] s1,
                                              input logic [5:0] inv);
    logic [5:0] y;
    y = ~a;
    case (m)
      1: y = y | 6'h08;
      2: begin
        y[0] = ~(a[0] | a[1]);
        y[1] = ~(a[0] | a[1]);
      end
      3: y = ((y ^ inv) & ~s0) | s1;
      default: y = ~a;
    endcase
    return y;
  endfunction

  assign yIn = channelModel(aOut, mode, stuck0, stuck1, invMask);

  // Slow ideal inverter: propagation just under one clock period
  assign #(2*CLK_HALF-1) yInF = ~aOutF;

  inverter_tester #(.SETTLE_CYCLES(S_MAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .a_out(aOut), .y_in(yIn), .busy(busy),
    .done(done), .pass(pass), .fail_mask(failMask), .err_count(errCount), .vec_idx(vecIdx)
  );

  inverter_tester #(.SETTLE_CYCLES(S_FAST)) dutFast (
    .clk(clk), .rst(rst), .start(startF), .a_out(aOutF), .y_in(yInF), .busy(busyF),
    .done(doneF), .pass(passF), .fail_mask(failMaskF), .err_count(errCountF), .vec_idx(vecIdxF)
  );

  assign obsBusy = sel ? busyF     : busy;
  assign obsDone = sel ? doneF     : done;
  assign obsPass = sel ? passF     : pass;
  assign obsA    = sel ? aOutF     : aOut;
  assign obsMask = sel ? failMaskF : failMask;
  assign obsErr  = sel ? errCountF : errCount;
  assign obsVec  = sel ? vecIdxF   : vecIdx;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveStart(input logic v);
    if (sel) startF = v;
    else     start  = v;
  endtask

  // Reference: walk the vector table and apply the comparison rule directly
  task automatic computeExpected(input int m, output logic [5:0] mask, output int err);
    logic [5:0] a, y, d;
    mask = 6'h00;
    err  = 0;
    for (int i = 0; i < 14; i++) begin
      a = vecTable[i];
      y = channelModel(a, m, stuck0, stuck1, invMask);
      d = y ^ ~a;
      if (d != 6'h00) err++;
      mask = mask | d;
    end
  endtask

  // One full run: latency, vector sequencing, results, and optional start interference
  task automatic applyStimulus(input bit useFast, input int s, input bit pulseAt5,
                               input bit holdStart, input string tag);
    logic [5:0] expMask;
    int         expErr, lat, t, doneT, seqBad, expVec;
    bit         expPass, doneSeen, pulsing;
    logic [5:0] gotMask;
    logic [3:0] gotErr;
    logic       gotPass;

    sel = useFast;
    computeExpected(useFast ? 0 : mode, expMask, expErr);
    expPass = (expMask == 6'h00);
    lat = 1 + 14 * (s + 1);

    @(negedge clk);
    driveStart(1'b1);
    @(negedge clk);
    if (!holdStart) driveStart(1'b0);

    t = 1; doneT = -1; seqBad = 0; doneSeen = 0; pulsing = 0;
    gotMask = 6'h00; gotErr = 4'd0; gotPass = 1'b0;
    while (!doneSeen && t <= lat + 5) begin
      if (pulsing) begin
        driveStart(1'b0);
        pulsing = 0;
      end
      if (obsDone === 1'b1) begin
        doneSeen = 1;
        doneT    = t;
        gotMask  = obsMask;
        gotErr   = obsErr;
        gotPass  = obsPass;
        if (obsBusy !== 1'b0) seqBad++;
      end else begin
        expVec = (t - 1) / (s + 1);
        if (expVec > 13) expVec = 13;
        if (obsBusy !== 1'b1 || obsVec !== 4'(expVec) || obsA !== vecTable[expVec]) seqBad++;
        if (pulseAt5 && expVec == 5 && ((t - 1) % (s + 1)) == 2) begin
          driveStart(1'b1);
          pulsing = 1;
        end
      end
      if (!doneSeen) begin
        @(negedge clk);
        t++;
      end
    end

    checkOutput({tag, "_latency"}, doneT, lat);
    checkOutput({tag, "_sequence"}, seqBad, 0);
    checkOutput({tag, "_pass"}, gotPass, expPass);
    checkOutput({tag, "_fail_mask"}, gotMask, expMask);
    checkOutput({tag, "_err_count"}, gotErr, expErr);

    @(negedge clk);
    checkOutput({tag, "_done_width"}, obsDone, 1'b0);

    if (holdStart) begin
      checkOutput({tag, "_idle_gap_busy"}, obsBusy, 1'b0);
      @(negedge clk);
      checkOutput({tag, "_restart_busy"}, obsBusy, 1'b1);
      checkOutput({tag, "_restart_clear"}, obsErr, 4'd0);
      driveStart(1'b0);
      t = 0; doneSeen = 0;
      while (!doneSeen && t <= lat + 5) begin
        @(negedge clk);
        t++;
        if (obsDone === 1'b1) doneSeen = 1;
      end
      checkOutput({tag, "_restart_latency"}, t, lat - 1);
      checkOutput({tag, "_restart_pass"}, obsPass, expPass);
      @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
      checkOutput({tag, "_hold_busy"}, obsBusy, 1'b0);
      checkOutput({tag, "_hold_a"}, obsA, 6'h1F);
      checkOutput({tag, "_hold_vec"}, obsVec, 4'd13);
      checkOutput({tag, "_hold_pass"}, obsPass, expPass);
      checkOutput({tag, "_hold_err"}, obsErr, expErr);
    end
  endtask

  // Abort a run at vector 6 with reset, then confirm the tester stays idle
  task automatic resetMidRun();
    int  t;
    int  doneHits;
    sel = 0;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (vecIdx !== 4'd6 && t < 400) begin
      @(negedge clk);
      t++;
    end
    checkOutput("abort_reach_vec6", vecIdx, 4'd6);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_a_out", aOut, 6'h00);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_vec", vecIdx, 4'd0);
    doneHits = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) doneHits++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) doneHits++;
    end
    checkOutput("abort_no_done_stay_idle", doneHits, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; startF = 1'b0; sel = 0;
    mode = 0; stuck0 = 6'h00; stuck1 = 6'h00; invMask = 6'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_a_out", aOut, 6'h00);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_pass", pass, 1'b0);
    checkOutput("reset_fail_mask", failMask, 6'h00);
    checkOutput("reset_err_count", errCount, 4'd0);
    checkOutput("reset_vec_idx", vecIdx, 4'd0);
    checkOutput("reset_fast_a_out", aOutF, 6'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_no_start", busy, 1'b0);

    mode = 0; applyStimulus(0, S_MAIN, 0, 0, "ideal");
    mode = 1; applyStimulus(0, S_MAIN, 0, 0, "stuck3");
    mode = 2; applyStimulus(0, S_MAIN, 0, 0, "short01");
    mode = 3; stuck0 = 6'h00; stuck1 = 6'h00; invMask = 6'h3F;
    applyStimulus(0, S_MAIN, 0, 0, "all_wrong");
    mode = 0; applyStimulus(0, S_MAIN, 1, 0, "start_ignored");
    mode = 1; applyStimulus(0, S_MAIN, 0, 1, "start_held");

    resetMidRun();
    mode = 0; applyStimulus(0, S_MAIN, 0, 0, "after_abort");

    for (int i = 0; i < 4; i++) begin
      mode    = 3;
      stuck0  = 6'($urandom & $urandom);
      stuck1  = 6'($urandom & $urandom) & ~stuck0;
      invMask = 6'($urandom & $urandom & $urandom);
      applyStimulus(0, S_MAIN, 0, 0, $sformatf("random%0d", i));
    end

    applyStimulus(1, S_FAST, 0, 0, "fast_delayed");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
